conv_mem_arb: RTL

- Shares the single-port conv SRAM among three requesters of the conv engine:
  - req 0: weight fetch (READ_W phase)
  - req 1: window pixel fetch (READ phase)
  - req 2: result write (WRITE phase)
- Round-robin arbitration over whole bursts.
- Generates burst addresses internally, strobes per-beat data, and returns read data one cycle after issue.
- Sits between the conv datapath fetch/write units and the SRAM macro. The top-level controller only raises requests.

---
 rtl/conv_mem_arb_pkg.sv | 29 ++
 rtl/conv_mem_arb_if.sv | 39 +++
 rtl/conv_mem_arb_rr_pick3.sv | 38 +++
 rtl/conv_mem_arb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/conv_mem_arb_pkg.sv
// Shared definitions for the conv SRAM arbiter: requester indices,
// FSM state encoding, default widths and the round-robin pointer helper.
package conv_mem_arb_pkg;

    localparam int REQ_W   = 0;
    localparam int REQ_PIX = 1;
    localparam int REQ_OUT = 2;
    localparam int NREQ    = 3;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        S_ARB_IDLE  = 2'b01,
        S_ARB_BURST = 2'b10
    } arb_state_e;

    // Pointer value after granting the one-hot winner: winner+1 mod 3.
    function automatic logic [1:0] rr_after(input logic [NREQ-1:0] win);
        logic [1:0] p;
        p = 2'(REQ_W);
        if (win[REQ_W])   p = 2'(REQ_PIX);
        if (win[REQ_PIX]) p = 2'(REQ_OUT);
        if (win[REQ_OUT]) p = 2'(REQ_W);
        return p;
    endfunction

endpackage

// File: rtl/conv_mem_arb_if.sv
// Requester and SRAM bus of the conv memory arbiter.
// slave: arbiter side; master: requesters + SRAM macro side.
interface conv_mem_arb_if
    import conv_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) ();

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*LEN_W-1:0]  len;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        beat;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic [NREQ-1:0]        done;
    logic                   mem_cen;
    logic                   mem_wen;
    logic [ADDR_W-1:0]      mem_a;
    logic [DATA_W-1:0]      mem_d;
    logic [DATA_W-1:0]      mem_q;

    modport slave (
        input  req, we, addr, len, wdata, mem_q,
        output gnt, beat, rvalid, rdata, done,
        output mem_cen, mem_wen, mem_a, mem_d
    );

    modport master (
        output req, we, addr, len, wdata, mem_q,
        input  gnt, beat, rvalid, rdata, done,
        input  mem_cen, mem_wen, mem_a, mem_d
    );

endinterface

// File: rtl/conv_mem_arb_rr_pick3.sv
// Combinational 3-way round-robin picker.
// req: requests, ptr: first index searched; win: one-hot winner, any: a request exists.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win,
    output logic       any
);

    logic [2:0] rot;
    logic [2:0] pick;

    // Rotate so bit 0 is the highest-priority requester, pick, rotate back.
    always_comb begin
        unique case (ptr)
            2'd1:    rot = {req[0], req[2], req[1]};
            2'd2:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
    end

    always_comb begin
        pick = 3'b000;
        if (rot[0])      pick = 3'b001;
        else if (rot[1]) pick = 3'b010;
        else if (rot[2]) pick = 3'b100;
    end

    always_comb begin
        unique case (ptr)
            2'd1:    win = {pick[1], pick[0], pick[2]};
            2'd2:    win = {pick[0], pick[2], pick[1]};
            default: win = pick;
        endcase
        any = |req;
    end

endmodule

// File: rtl/conv_mem_arb.sv
// Shares the single-port conv SRAM among weight fetch, pixel fetch and result write.
// clk/reset plain; bus (slave): burst requests in, grants/strobes/read data out, SRAM pins.
module conv_mem_arb
    import conv_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input logic           clk,
    input logic           reset,
    conv_mem_arb_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic [NREQ-1:0]   own_q, own_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   rv_q, rv_d;
    logic [NREQ-1:0]   done_q, done_d;

    logic [NREQ-1:0]   win;
    logic              any;
    logic              in_burst;
    logic              last;
    logic [ADDR_W-1:0] addr_sel;
    logic [LEN_W-1:0]  len_sel;
    logic              we_sel;
    logic [DATA_W-1:0] wd_sel;

    rr_pick3 u_pick (
        .req (bus.req),
        .ptr (rr_q),
        .win (win),
        .any (any)
    );

    assign in_burst = (state_q == S_ARB_BURST);
    assign last     = (cnt_q == '0);

    // Winner's request fields for latching, owner's write data for mem_d.
    always_comb begin
        addr_sel = '0;
        len_sel  = '0;
        we_sel   = 1'b0;
        wd_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                addr_sel = bus.addr[i*ADDR_W +: ADDR_W];
                len_sel  = bus.len[i*LEN_W +: LEN_W];
                we_sel   = bus.we[i];
            end
            if (own_q[i]) begin
                wd_sel = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ARB_IDLE;
            rr_q    <= 2'd0;
            own_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rv_q    <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ARB_IDLE:  if (any) state_d = S_ARB_BURST;
            S_ARB_BURST: if (last) state_d = S_ARB_IDLE;
            default:     state_d = S_ARB_IDLE;
        endcase
    end

    always_comb begin
        rr_d   = rr_q;
        own_d  = own_q;
        we_d   = we_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        rv_d   = '0;
        done_d = '0;
        if (state_q == S_ARB_IDLE && any) begin
            own_d  = win;
            we_d   = we_sel;
            addr_d = addr_sel;
            cnt_d  = len_sel;
            rr_d   = rr_after(win);
        end
        if (in_burst) begin
            addr_d = addr_q + ADDR_W'(1);
            // Read data returns one cycle after its beat.
            rv_d   = we_q ? '0 : own_q;
            if (last) begin
                own_d  = '0;
                done_d = own_q;
            end else begin
                cnt_d = cnt_q - LEN_W'(1);
            end
        end
    end

    always_comb begin
        bus.gnt     = own_q;
        bus.beat    = '0;
        bus.mem_cen = 1'b0;
        bus.mem_wen = 1'b0;
        bus.mem_a   = '0;
        bus.mem_d   = '0;
        if (in_burst) begin
            bus.beat    = own_q;
            bus.mem_cen = 1'b1;
            bus.mem_wen = we_q;
            bus.mem_a   = addr_q;
            bus.mem_d   = wd_sel;
        end
        bus.rvalid = rv_q;
        bus.done   = done_q;
        // mem_q is the macro's output register; expose it while a read returns.
        bus.rdata  = (|rv_q) ? bus.mem_q : '0;
    end

endmodule
